pipeline_credit_rx: RTL and testbench

Terminating end of a valid-only, fixed-latency generated pipeline with `input_valid`/`output_valid` and no stall. The block sits between a ready/valid producer and the pipeline, and between the pipeline and a ready/valid consumer. It gates launches into the pipeline using a credit counter, so results never outnumber buffer space. Returned results are captured in a small FIFO and presented downstream with backpressure.

---
 rtl/pipeline_credit_rx_pkg.sv | 18 +
 rtl/pipeline_credit_rx_fifo.sv | 94 +++++++++
 rtl/pipeline_credit_rx.sv | 81 ++++++++
 tb/tb_pipeline_credit_rx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_credit_rx_pkg.sv
// Shared definitions for the credit-gated pipeline receiver.
package pipeline_credit_rx_pkg;

    // Default sizing used by the top level and its FIFO.
    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultDepth     = 4;

    // Width needed to hold any value 0..depth (credits and FIFO count).
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; at least one bit so a single-entry FIFO still has a legal vector.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipeline_credit_rx_fifo.sv
// Result FIFO for the credit-gated pipeline receiver. Arbitrary depth (pointers
// wrap by compare), registered count, no bypass, sticky overflow on a dropped write.
module pipeline_credit_rx_fifo
    import pipeline_credit_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [credit_width(DEPTH)-1:0]  count,
    output logic                            overflow
);

    localparam int unsigned CntW = credit_width(DEPTH);
    localparam int unsigned PtrW = ptr_width(DEPTH);

    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;

    logic empty;
    logic full;
    logic do_rd;
    logic do_wr;

    // Next-state for pointers, count and the sticky overflow flag.
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CntFull);
        // A write into a full FIFO is still accepted when a read frees a slot this cycle.
        do_rd      = rd_en && !empty;
        do_wr      = wr_en && (!full || do_rd);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Dropped write: the credit loop and the pipeline disagree.
        if (wr_en && full && !do_rd) begin
            overflow_d = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; contents are left unreset since they are masked by count.
    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/pipeline_credit_rx.sv
// Terminating end of a valid-only fixed-latency pipeline. Launches are gated by
// a credit counter so results never outnumber FIFO space; results drain downstream
// through a ready/valid interface with backpressure.
module pipeline_credit_rx
    import pipeline_credit_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned DEPTH      = DefaultDepth
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            src_valid,
    output logic                            src_ready,
    input  logic [DATA_WIDTH-1:0]           src_data,
    output logic                            pipe_input_valid,
    output logic [DATA_WIDTH-1:0]           pipe_x,
    input  logic                            pipe_output_valid,
    input  logic [DATA_WIDTH-1:0]           pipe_out,
    output logic                            dst_valid,
    input  logic                            dst_ready,
    output logic [DATA_WIDTH-1:0]           dst_data,
    output logic [credit_width(DEPTH)-1:0]  credits,
    output logic                            overflow
);

    localparam int unsigned CntW = credit_width(DEPTH);

    localparam logic [CntW-1:0] CreditsMax = CntW'(DEPTH);

    logic [CntW-1:0] credits_q, credits_d;
    logic [CntW-1:0] fifo_count;
    logic            launch;
    logic            deq;

    // Handshake glue: launch into the pipeline, dequeue toward the consumer.
    always_comb begin
        src_ready        = (credits_q != '0) && !rst;
        launch           = src_valid && src_ready;
        pipe_input_valid = launch;
        pipe_x           = src_data;
        dst_valid        = (fifo_count != '0);
        deq              = dst_valid && dst_ready;
    end

    // Credit next-state: one credit per launch, returned when its result leaves the FIFO.
    always_comb begin
        credits_d = credits_q;
        unique case ({launch, deq})
            2'b10:   credits_d = credits_q - 1'b1;
            // Saturate so an injected/stray result can never push credits past DEPTH.
            2'b01:   credits_d = (credits_q == CreditsMax) ? credits_q : credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    // Credit register with synchronous reset to a full allowance.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CreditsMax;
        end else begin
            credits_q <= credits_d;
        end
    end

    pipeline_credit_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (pipe_output_valid),
        .wr_data  (pipe_out),
        .rd_en    (deq),
        .rd_data  (dst_data),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign credits = credits_q;

endmodule

// File: tb/tb_pipeline_credit_rx.sv
// Directed bench for pipeline_credit_rx (DEPTH=4) against a 3-stage "+1" pipeline model.
module tb_pipeline_credit_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_valid;
    logic          src_ready;
    logic [DW-1:0] src_data;
    logic          pipe_input_valid;
    logic [DW-1:0] pipe_x;
    logic          pipe_output_valid;
    logic [DW-1:0] pipe_out;
    logic          dst_valid;
    logic          dst_ready;
    logic [DW-1:0] dst_data;
    logic [CW-1:0] credits;
    logic          overflow;

    logic          inj_valid;
    logic [DW-1:0] inj_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    pipeline_credit_rx #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_data          (src_data),
        .pipe_input_valid  (pipe_input_valid),
        .pipe_x            (pipe_x),
        .pipe_output_valid (pipe_output_valid),
        .pipe_out          (pipe_out),
        .dst_valid         (dst_valid),
        .dst_ready         (dst_ready),
        .dst_data          (dst_data),
        .credits           (credits),
        .overflow          (overflow)
    );

    // Pipeline model: 3 stages, result = operand + 1, valid chain cleared by rst.
    logic [2:0]    p_v;
    logic [DW-1:0] p_d0, p_d1, p_d2;
    always @(posedge clk) begin
        if (rst) begin
            p_v <= 3'b000;
        end else begin
            p_v  <= {p_v[1:0], pipe_input_valid};
            p_d0 <= pipe_x + 32'd1;
            p_d1 <= p_d0;
            p_d2 <= p_d1;
        end
    end
    assign pipe_output_valid = p_v[2] | inj_valid;
    assign pipe_out          = inj_valid ? inj_data : p_d2;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; src_valid = 1'b1; src_data = 32'h99; dst_ready = 1'b0;
        tick(); tick();
        #1;
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL rst_src_ready got %0b want 0", src_ready); end
        checks++; if (pipe_input_valid !== 1'b0) begin errors++; $display("FAIL rst_pipe_valid got %0b want 0", pipe_input_valid); end
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL rst_dst_valid got %0b want 0", dst_valid); end
        rst = 1'b0; src_valid = 1'b0;
        #1;
        checks++; if (credits !== 3'd4) begin errors++; $display("FAIL reset_credits got %0d want 4", credits); end
        checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_src_ready got %0b want 1", src_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL reset_dst_valid got %0b want 0", dst_valid); end
    endtask

    task automatic test_burst();
        int launched = 0;
        dst_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            src_valid = 1'b1;
            src_data  = 32'h10 + launched;
            #1;
            if (pipe_input_valid) launched++;
            tick();
        end
        #1;
        checks++; if (launched != 4) begin errors++; $display("FAIL burst_launches got %0d want 4", launched); end
        checks++; if (credits !== 3'd0) begin errors++; $display("FAIL burst_credits got %0d want 0", credits); end
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL burst_src_ready got %0b want 0", src_ready); end
        checks++; if (pipe_input_valid !== 1'b0) begin errors++; $display("FAIL burst_blocked got %0b want 0", pipe_input_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow got %0b want 0", overflow); end
        checks++; if (dst_valid !== 1'b1 || dst_data !== 32'h11) begin errors++; $display("FAIL burst_head got v=%0b d=%0h want v=1 d=11", dst_valid, dst_data); end
        tick();
        checks++; if (dst_data !== 32'h11) begin errors++; $display("FAIL burst_stable got %0h want 11", dst_data); end
    endtask

    task automatic test_drain();
        src_valid = 1'b0; dst_ready = 1'b1;
        #1;
        checks++; if (dst_data !== 32'h11) begin errors++; $display("FAIL drain_first got %0h want 11", dst_data); end
        tick();
        checks++; if (dst_data !== 32'h12) begin errors++; $display("FAIL drain_second got %0h want 12", dst_data); end
        tick();
        dst_ready = 1'b0;
        #1;
        checks++; if (credits !== 3'd2) begin errors++; $display("FAIL drain_credits got %0d want 2", credits); end
        checks++; if (dst_data !== 32'h13) begin errors++; $display("FAIL drain_head got %0h want 13", dst_data); end
        src_valid = 1'b1; src_data = 32'h14;
        #1;
        checks++; if (pipe_input_valid !== 1'b1) begin errors++; $display("FAIL drain_launch14 got %0b want 1", pipe_input_valid); end
        tick();
        src_data = 32'h15;
        #1;
        checks++; if (pipe_input_valid !== 1'b1) begin errors++; $display("FAIL drain_launch15 got %0b want 1", pipe_input_valid); end
        tick();
        src_data = 32'h16;
        #1;
        checks++; if (pipe_input_valid !== 1'b0 || credits !== 3'd0) begin errors++; $display("FAIL drain_exhausted got v=%0b c=%0d want v=0 c=0", pipe_input_valid, credits); end
        src_valid = 1'b0;
        repeat (5) tick();
        checks++; if (overflow !== 1'b0 || dst_valid !== 1'b1 || dst_data !== 32'h13) begin
            errors++; $display("FAIL drain_refill got o=%0b v=%0b d=%0h want o=0 v=1 d=13", overflow, dst_valid, dst_data);
        end
    endtask

    // FIFO holds 13,14,15,16 (full); push A0 while popping 13 in the same cycle.
    task automatic test_full_simul();
        logic [DW-1:0] exp_q [4];
        exp_q[0] = 32'h14; exp_q[1] = 32'h15; exp_q[2] = 32'h16; exp_q[3] = 32'hA0;
        inj_valid = 1'b1; inj_data = 32'hA0; dst_ready = 1'b1;
        #1;
        checks++; if (dst_valid !== 1'b1 || dst_data !== 32'h13) begin errors++; $display("FAIL simul_head got v=%0b d=%0h want v=1 d=13", dst_valid, dst_data); end
        tick();
        inj_valid = 1'b0; dst_ready = 1'b0;
        #1;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %0b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            dst_ready = 1'b1;
            #1;
            checks++; if (dst_valid !== 1'b1 || dst_data !== exp_q[i]) begin
                errors++; $display("FAIL simul_order[%0d] got v=%0b d=%0h want v=1 d=%0h", i, dst_valid, dst_data, exp_q[i]);
            end
            tick();
        end
        dst_ready = 1'b0;
        #1;
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got %0b want 0", dst_valid); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src_data = 32'h30 + i;
            tick();
        end
        src_valid = 1'b0;
        #1;
        checks++; if (credits !== 3'd1) begin errors++; $display("FAIL midrst_credits_before got %0d want 1", credits); end
        rst = 1'b1; tick(); rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                #1;
                if (dst_valid) seen++;
                tick();
            end
            checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale got %0d valid cycles want 0", seen); end
        end
        checks++; if (credits !== 3'd4) begin errors++; $display("FAIL midrst_credits got %0d want 4", credits); end
    endtask

    // Ten items through DEPTH=4: in order, each visible exactly 4 cycles after launch.
    task automatic test_streaming();
        int launch_cyc [10];
        int sent = 0;
        int rx   = 0;
        dst_ready = 1'b1;
        for (int i = 0; i < 60 && rx < 10; i++) begin
            src_valid = (sent < 10);
            src_data  = 32'h40 + sent;
            #1;
            if (pipe_input_valid) begin
                launch_cyc[sent] = cyc;
                sent++;
            end
            if (dst_valid) begin
                checks++; if (dst_data !== 32'h41 + rx || cyc - launch_cyc[rx] != 4) begin
                    errors++; $display("FAIL stream[%0d] got d=%0h lat=%0d want d=%0h lat=4", rx, dst_data, cyc - launch_cyc[rx], 32'h41 + rx);
                end
                rx++;
            end
            tick();
        end
        src_valid = 1'b0;
        dst_ready = 1'b0;
        #1;
        checks++; if (rx != 10) begin errors++; $display("FAIL stream_count got %0d want 10", rx); end
        checks++; if (credits !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL stream_end got c=%0d o=%0b want c=4 o=0", credits, overflow); end
    endtask

    task automatic test_overflow();
        dst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inj_valid = 1'b1; inj_data = 32'hB0 + i;
            tick();
        end
        inj_valid = 1'b0;
        #1;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
        checks++; if (dst_data !== 32'hB0) begin errors++; $display("FAIL ovf_head got %0h want b0", dst_data); end
        repeat (3) tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            dst_ready = 1'b1;
            #1;
            checks++; if (dst_valid !== 1'b1 || dst_data !== 32'hB0 + i) begin
                errors++; $display("FAIL ovf_drain[%0d] got v=%0b d=%0h want v=1 d=%0h", i, dst_valid, dst_data, 32'hB0 + i);
            end
            tick();
        end
        dst_ready = 1'b0;
        #1;
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped got %0b want 0", dst_valid); end
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        checks++; if (overflow !== 1'b0 || credits !== 3'd4) begin errors++; $display("FAIL ovf_reset got o=%0b c=%0d want o=0 c=4", overflow, credits); end
    endtask

    initial begin
        rst = 1'b1; src_valid = 1'b0; src_data = '0; dst_ready = 1'b0;
        inj_valid = 1'b0; inj_data = '0;
        test_reset();
        test_burst();
        test_drain();
        test_full_simul();
        test_mid_reset();
        test_streaming();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
